// File: rtl/logic_unit_sequencer.sv
// Sweeps the operand ROM and drives the OR / AND / NAND logic unit, registering
// each result to the LEDs with either an automatic dwell or manual stepping.
module logic_unit_sequencer #(
    parameter int ADDR_W      = 4,
    parameter int NUM_ENTRIES = 8,
    parameter int DWELL       = 50000000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic              step,
    input  logic              auto_mode,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [7:0]        op_a,
    output logic [7:0]        op_b,
    output logic [2:0]        switches,
    input  logic [7:0]        result,
    output logic [7:0]        led,
    output logic              result_valid,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_LOAD  = 3'd3;
    localparam logic [2:0] S_EXEC  = 3'd4;
    localparam logic [2:0] S_SHOW  = 3'd5;
    localparam logic [2:0] S_NEXT  = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    localparam int              CNT_W      = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ENTRIES - 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        op_idx_q, op_idx_d;
    logic [CNT_W-1:0]  dwell_q, dwell_d;
    logic [7:0]        op_a_q, op_a_d;
    logic [7:0]        op_b_q, op_b_d;
    logic [2:0]        sw_q, sw_d;
    logic [7:0]        led_q, led_d;
    logic              rv_q, rv_d;

    function automatic logic [2:0] opcode(input logic [1:0] idx);
        case (idx)
            2'd0:    opcode = 3'b010;
            2'd1:    opcode = 3'b011;
            default: opcode = 3'b100;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        op_idx_d = op_idx_q;
        dwell_d  = dwell_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        led_d    = led_q;
        rv_d     = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d  = S_FETCH;
                        addr_d   = '0;
                        op_idx_d = '0;
                    end
                end
                S_FETCH: state_d = S_WAIT;
                S_WAIT:  state_d = S_LOAD;
                S_LOAD: begin
                    op_a_d  = rom_data[15:8];
                    op_b_d  = rom_data[7:0];
                    state_d = S_EXEC;
                end
                S_EXEC: begin
                    led_d   = result;
                    rv_d    = 1'b1;
                    dwell_d = '0;
                    state_d = S_SHOW;
                end
                S_SHOW: begin
                    // Manual mode freezes the dwell count so a switch back to auto resumes it
                    if (auto_mode) begin
                        if (dwell_q == DWELL_LAST) begin
                            state_d = S_NEXT;
                        end else begin
                            dwell_d = dwell_q + 1'b1;
                        end
                    end else if (step) begin
                        state_d = S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (op_idx_q < 2'd2) begin
                        op_idx_d = op_idx_q + 1'b1;
                        state_d  = S_EXEC;
                    end else begin
                        op_idx_d = '0;
                        if (addr_q == LAST_ADDR) begin
                            state_d = S_DONE;
                        end else begin
                            addr_d  = addr_q + 1'b1;
                            state_d = S_FETCH;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Opcode is registered so it is stable for the whole EXEC cycle
        sw_d = ((state_d == S_EXEC) || (state_d == S_SHOW)) ? opcode(op_idx_d) : 3'b000;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            op_idx_q <= '0;
            dwell_q  <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            sw_q     <= '0;
            led_q    <= '0;
            rv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            op_idx_q <= op_idx_d;
            dwell_q  <= dwell_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            sw_q     <= sw_d;
            led_q    <= led_d;
            rv_q     <= rv_d;
        end
    end

    assign rom_addr     = addr_q;
    assign op_a         = op_a_q;
    assign op_b         = op_b_q;
    assign switches     = sw_q;
    assign led          = led_q;
    assign result_valid = rv_q;
    assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done         = (state_q == S_DONE);

endmodule
